// File: rtl/dilater_if.sv
// Pixel stream bundle shared by the morphology stages: raster-position input
// stream and the registered, centre-tagged result stream.
interface dilater_if #(
    parameter int POS_W = 11
);
    logic [POS_W-1:0] hpos;
    logic [POS_W-1:0] vpos;
    logic             in_pix;
    logic             out_pix;
    logic [POS_W-1:0] out_hpos;
    logic [POS_W-1:0] out_vpos;
    logic             out_valid;

    modport master (
        output hpos, vpos, in_pix,
        input  out_pix, out_hpos, out_vpos, out_valid
    );

    modport slave (
        input  hpos, vpos, in_pix,
        output out_pix, out_hpos, out_vpos, out_valid
    );
endinterface

// File: rtl/dilater.sv
// 3x3 binary dilation on a raster pixel stream: two line buffers feed a
// window of column taps; each result is the OR of the edge-masked window.
module dilater #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int POS_W    = 11
) (
    input logic      clk,
    input logic      rst,
    dilater_if.slave io
);
    localparam int               AW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [POS_W-1:0] H_LAST = POS_W'(H_ACTIVE - 1);
    localparam logic [POS_W-1:0] V_LAST = POS_W'(V_ACTIVE - 1);

    logic [H_ACTIVE-1:0] lb1_q, lb1_d, lb2_q, lb2_d;
    // column taps: bit2 = top row, bit1 = centre row, bit0 = bottom row
    logic [2:0]          col1_q, col1_d, col2_q, col2_d;
    logic                seen_q, seen_d;
    logic                out_pix_q, out_pix_d;
    logic                out_valid_q, out_valid_d;
    logic [POS_W-1:0]    out_hpos_q, out_hpos_d;
    logic [POS_W-1:0]    out_vpos_q, out_vpos_d;

    logic                active;
    logic [AW-1:0]       addr;
    logic [2:0]          tap;
    logic [2:0]          row_en;
    logic [POS_W-1:0]    cx, cy;
    logic                win_or;

    always_comb begin
        active = (io.hpos < POS_W'(H_ACTIVE)) && (io.vpos < POS_W'(V_ACTIVE));
        addr   = io.hpos[AW-1:0];
        tap    = {lb2_q[addr], lb1_q[addr], io.in_pix};

        // A row's last centre only completes after the following row has
        // produced its taps, so at hpos==0 the centre sits two rows back.
        if (io.hpos == '0) begin
            cx = H_LAST;
            if (io.vpos == '0)              cy = V_LAST - POS_W'(1);
            else if (io.vpos == POS_W'(1))  cy = V_LAST;
            else                            cy = io.vpos - POS_W'(2);
        end else begin
            cx = io.hpos - POS_W'(1);
            cy = (io.vpos == '0) ? V_LAST : io.vpos - POS_W'(1);
        end

        row_en = {cy != '0, 1'b1, cy != V_LAST};
        win_or = (|(col2_q & row_en & {3{cx != '0}}))
               | (|(col1_q & row_en))
               | (|(tap & row_en & {3{cx != H_LAST}}));

        lb1_d       = lb1_q;
        lb2_d       = lb2_q;
        col1_d      = col1_q;
        col2_d      = col2_q;
        seen_d      = seen_q;
        out_pix_d   = 1'b0;
        out_valid_d = 1'b0;
        out_hpos_d  = out_hpos_q;
        out_vpos_d  = out_vpos_q;

        if (active) begin
            lb2_d[addr] = lb1_q[addr];
            lb1_d[addr] = io.in_pix;
            col2_d      = col1_q;
            col1_d      = tap;
            seen_d      = 1'b1;
            out_pix_d   = win_or;
            out_valid_d = !(!seen_q && io.hpos == '0 && io.vpos == '0);
            out_hpos_d  = cx;
            out_vpos_d  = cy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lb1_q       <= '0;
            lb2_q       <= '0;
            col1_q      <= '0;
            col2_q      <= '0;
            seen_q      <= 1'b0;
            out_pix_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_hpos_q  <= '0;
            out_vpos_q  <= '0;
        end else begin
            lb1_q       <= lb1_d;
            lb2_q       <= lb2_d;
            col1_q      <= col1_d;
            col2_q      <= col2_d;
            seen_q      <= seen_d;
            out_pix_q   <= out_pix_d;
            out_valid_q <= out_valid_d;
            out_hpos_q  <= out_hpos_d;
            out_vpos_q  <= out_vpos_d;
        end
    end

    assign io.out_pix   = out_pix_q;
    assign io.out_valid = out_valid_q;
    assign io.out_hpos  = out_hpos_q;
    assign io.out_vpos  = out_vpos_q;
endmodule

// File: tb/tb_dilater.sv
// Randomised raster stimulus against a frame-image model of 3x3 dilation.
module tb_dilater;
    localparam int H_A   = 16;
    localparam int V_A   = 12;
    localparam int H_T   = 20;
    localparam int V_T   = 15;
    localparam int POS_W = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dilater_if #(.POS_W(POS_W)) io ();

    dilater #(.H_ACTIVE(H_A), .V_ACTIVE(V_A), .POS_W(POS_W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // model: two frame images, ping-ponged at each (0,0) active sample
    bit img [2][V_A][H_A];
    int fp   = 0;
    bit seen = 0;
    bit have_exp = 0;
    bit e_pix, e_valid, e_pos;
    int e_h, e_v;
    int vcnt;

    task automatic clear_img(input int f);
        for (int y = 0; y < V_A; y++)
            for (int x = 0; x < H_A; x++) img[f][y][x] = 1'b0;
    endtask

    task automatic step(input bit r, input int h, input int v, input bit p);
        int q, fr, cx, cy;
        @(negedge clk);
        if (have_exp) begin
            chk("out_valid", int'(io.out_valid), int'(e_valid));
            chk("out_pix", int'(io.out_pix), int'(e_pix));
            if (e_pos) begin
                chk("out_hpos", int'(io.out_hpos), e_h);
                chk("out_vpos", int'(io.out_vpos), e_v);
            end
            if (io.out_valid) vcnt++;
        end
        rst       = r;
        io.hpos   = POS_W'(h);
        io.vpos   = POS_W'(v);
        io.in_pix = p;
        have_exp  = 1'b1;
        e_pix = 1'b0; e_valid = 1'b0; e_pos = 1'b0; e_h = 0; e_v = 0;
        if (r) begin
            clear_img(0);
            clear_img(1);
            seen  = 1'b0;
            e_pos = 1'b1;
        end else if (h < H_A && v < V_A) begin
            if (h == 0 && v == 0) begin
                fp = fp ^ 1;
                clear_img(fp);
            end
            img[fp][v][h] = p;
            // centre lags the input by one line plus one pixel in raster order
            q  = v * H_A + h - H_A - 1;
            fr = fp;
            if (q < 0) begin
                q  += H_A * V_A;
                fr = fp ^ 1;
            end
            cx = q % H_A;
            cy = q / H_A;
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++)
                    if (cx + dx >= 0 && cx + dx < H_A && cy + dy >= 0 && cy + dy < V_A)
                        e_pix |= img[fr][cy+dy][cx+dx];
            e_valid = !(!seen && h == 0 && v == 0);
            seen    = 1'b1;
            e_pos   = e_valid;
            e_h     = cx;
            e_v     = cy;
        end
    endtask

    function automatic bit pix_of(input int mode, input int h, input int v);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (h == 10 && v == 6);
            3:       return (h == 0 && v == 0) || (h == H_A-1 && v == V_A-1);
            4:       return ((h > 2 && h < 8) || (h > 11 && h < 14)) && v > 1 && v < 9;
            5:       return ($urandom_range(3) == 0);
            default: return 1'($urandom);
        endcase
    endfunction

    task automatic run_frame(input int mode, input int rst_h, input int rst_v);
        int exp_cnt;
        bit act, r, p;
        exp_cnt = seen ? H_A * V_A : H_A * V_A - 1;
        vcnt = 0;
        for (int v = 0; v < V_T; v++)
            for (int h = 0; h < H_T; h++) begin
                act = (h < H_A) && (v < V_A);
                p   = act ? pix_of(mode, h, v) : 1'($urandom);
                r   = (v == rst_v) && (h == rst_h || h == rst_h + 1);
                step(r, h, v, p);
            end
        if (rst_v < 0) chk("valid_cnt", vcnt, exp_cnt);
    endtask

    initial begin
        rst = 1'b1; io.hpos = '0; io.vpos = '0; io.in_pix = 1'b0;
        step(1'b1, 0, 0, 1'b1);
        step(1'b1, 3, 0, 1'b1);
        run_frame(0, -1, -1);
        run_frame(2, -1, -1);
        run_frame(3, -1, -1);
        run_frame(0, -1, -1);
        run_frame(4, -1, -1);
        run_frame(1, -1, -1);
        run_frame(1, -1, -1);
        run_frame(0, -1, -1);
        run_frame(4, 8, 6);
        run_frame(4, -1, -1);
        run_frame(3, -1, -1);
        for (int i = 0; i < 4; i++) run_frame(5 + (i & 1), -1, -1);
        run_frame(1, 0, 0);
        run_frame(6, -1, -1);
        step(1'b0, H_T - 1, V_T - 1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
